// File: rtl/jtkiwi_gfx_arb.sv
// Shares one SDRAM read slot between the scroll and object graphics fetchers.
// Each requester keeps a one-entry hit buffer so ok follows its current address.
module jtkiwi_gfx_arb #(
  parameter int unsigned AW         = 18,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_ok
);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t        state;
  logic          owner;       // 1 = obj, 0 = scr
  logic          last_grant;  // 1 = obj, 0 = scr
  logic          scr_valid, obj_valid;
  logic [AW-1:0] scr_tag, obj_tag;

  logic scr_hit, obj_hit, scr_req, obj_req, grant_obj, owner_match;

  // Hit detection and request generation from the current addresses
  always_comb begin
    scr_hit = scr_valid & (scr_tag == scr_addr);
    obj_hit = obj_valid & (obj_tag == obj_addr);
    scr_req = scr_cs & ~scr_hit;
    obj_req = obj_cs & ~obj_hit;
  end

  assign scr_ok = scr_cs & scr_hit;
  assign obj_ok = obj_cs & obj_hit;

  // Tie break: round-robin against the last grant, or obj when priority is fixed
  always_comb begin
    grant_obj = 1'b0;
    if (obj_req && !scr_req) begin
      grant_obj = 1'b1;
    end else if (obj_req && scr_req) begin
      grant_obj = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
    end
  end

  // Returned data is only kept if the owner still wants that exact word
  always_comb begin
    owner_match = owner ? (obj_cs & (obj_addr == mem_addr))
                        : (scr_cs & (scr_addr == mem_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mem_cs     <= 1'b0;
      mem_addr   <= '0;
      scr_valid  <= 1'b0;
      obj_valid  <= 1'b0;
      scr_tag    <= '0;
      obj_tag    <= '0;
      scr_data   <= '0;
      obj_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scr_req || obj_req) begin
            owner      <= grant_obj;
            last_grant <= grant_obj;
            mem_addr   <= grant_obj ? obj_addr : scr_addr;
            mem_cs     <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ok) begin
            mem_cs <= 1'b0;
            state  <= GAP;
            if (owner_match) begin
              if (owner) begin
                obj_valid <= 1'b1;
                obj_tag   <= mem_addr;
                obj_data  <= mem_data;
              end else begin
                scr_valid <= 1'b1;
                scr_tag   <= mem_addr;
                scr_data  <= mem_data;
              end
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jtkiwi_gfx_arb.md
Name: jtkiwi_gfx_arb

Overview:
- Shares one SDRAM read slot between the scroll (scr) and object (obj) graphics fetchers of the Kiwi video pipeline.
- Sits between the tile/object engines and the jtframe SDRAM bank port.
- Arbitrates one outstanding 32-bit read at a time.
- Keeps a one-entry hit buffer per requester so each requester's ok/data obey the usual "ok while address matches" semantics.

Parameters:
- AW, 18: address width; addresses are word addresses [19:2].
- DW, 32: data width.
- FIXED_PRIO, 0: 0 = round-robin on simultaneous requests; 1 = obj always wins ties.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- scr_cs, input, 1: scroll fetch request; held until scr_ok.
- scr_addr, input, AW: scroll word address [19:2].
- scr_data, output, DW: scroll read data.
- scr_ok, output, 1: scr_data valid for the current scr_addr.
- obj_cs, input, 1: object fetch request.
- obj_addr, input, AW: object word address [19:2].
- obj_data, output, DW: object read data.
- obj_ok, output, 1: obj_data valid for the current obj_addr.
- mem_cs, output, 1: SDRAM read request; held until mem_ok.
- mem_addr, output, AW: SDRAM word address.
- mem_data, input, DW: SDRAM read data, valid with mem_ok.
- mem_ok, input, 1: SDRAM data strobe, one cycle or more.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; mem_cs=0; mem_addr=0.
  - Both buffers invalid, tags=0, data=0.
  - scr_ok=obj_ok=0; scr_data=obj_data=0.
  - last_grant=obj, so the first tie goes to scr.
- Per-requester buffer: valid bit, AW tag, DW data.
  - hit_x = valid_x & (tag_x == x_addr).
  - x_ok = x_cs & hit_x, combinational.
  - x_data = data_x, a register.
  - A requester with a hit needs no memory access and can see ok in the same cycle its address matches.
- Miss: req_x = x_cs & ~hit_x.
- State machine, states IDLE, WAIT, GAP:
  - IDLE, no request: stay.
  - IDLE, exactly one request: grant it.
  - IDLE, both requesting, FIXED_PRIO=0: grant the requester that is not last_grant.
  - IDLE, both requesting, FIXED_PRIO=1: grant obj.
  - On grant: owner<=x; last_grant<=x; mem_addr<=x_addr; mem_cs<=1; go WAIT.
  - WAIT, mem_ok=0: hold mem_cs and mem_addr stable.
  - WAIT, mem_ok=1: mem_cs<=0.
    - If owner_cs is still high and owner_addr==mem_addr: valid<=1, tag<=mem_addr, data<=mem_data for the owner only.
    - Otherwise, due to address change or cs drop mid-flight, discard the data; the owner's buffer is unchanged.
    - Go GAP.
  - GAP: mem_cs stays 0 for exactly one cycle; go IDLE. This guarantees mem_cs low between transactions.
- Latency for a miss with request at cycle 0 and mem_ok at cycle N:
  - mem_cs rises at cycle 1.
  - x_ok is high from cycle N+1 as long as cs and addr are held.
  - Earliest next grant is cycle N+2.
- Address change by a non-owner while another transaction is in flight: the request is simply re-evaluated in IDLE.
- mem_ok while in IDLE or GAP: ignored.
- Buffers are never invalidated except by reset; the graphics ROM is read-only.
- A requester dropping cs keeps its buffer, so a later request to the same address hits immediately.
- mem_addr changes only on grant and holds through WAIT.

Test Plan:
- Reset with scr_cs=1 asserted -> mem_cs=0, scr_ok=0, scr_data=0. Release rst_n -> mem_cs=1 and mem_addr=scr_addr one cycle later.
- scr_cs=1, scr_addr=0x01234; memory model returns 0xDEADBEEF with mem_ok 5 cycles after mem_cs -> scr_ok=1 and scr_data=0xDEADBEEF the next cycle. mem_cs low for 1 GAP cycle. Re-assert after cs drop -> scr_ok in the same cycle, no mem_cs.
- scr_cs and obj_cs rise together at addresses 0x00010 and 0x20000, FIXED_PRIO=0 -> grants go scr then obj, with GAP between. Repeat with new addresses -> scr granted first again, since last_grant=obj. FIXED_PRIO=1 -> obj first.
- obj_addr changes from 0x00100 to 0x00104 during WAIT -> data for 0x00100 discarded and obj_ok stays 0. A second transaction for 0x00104 follows, then obj_ok=1 with the correct data.
- rst_n pulsed low during WAIT -> mem_cs drops asynchronously and buffers are invalidated. A late mem_ok after release is ignored, and scr_ok stays 0 until a fresh fetch.
- 1000 random cycles with two requesters and random mem_ok delays of 1-10 cycles -> check all of:
  - ok is never high with data mismatching the model ROM;
  - mem_cs is never high for two transactions without a low cycle between them;
  - every held request eventually receives ok.
